onehot_key_capture: RTL and testbench
=====================================

Name: onehot_key_capture

Overview:
Front-end stage that sits directly upstream of the 8-to-3 encoder. It synchronizes and debounces eight raw active-high key lines. It accepts only clean single-key presses and presents them on Data_out as a held one-hot byte for the encoder to consume. Each accepted press is signalled with a Valid/Ack handshake, and a full debounced release is required before the next press is accepted.

Parameters:
DEBOUNCE_CYCLES, 16, number of consecutive identical synchronized samples required to accept a press or a release; legal range >= 2.
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width; derived, not overridden.

Ports:
Clk  input  1  system clock, all logic on rising edge.
Reset  input  1  synchronous, active-high reset.
Keys_in  input  8  raw asynchronous key lines, bit i high = key i pressed.
Ack  input  1  consumer acknowledge; sampled only while Valid=1.
Data_out  output  8  captured one-hot key code; feeds encoder Data_in.
Valid  output  1  level; high while an unacknowledged press is presented.
Multi_err  output  1  one-cycle pulse when a debounce is aborted by more than one key being high.

Behaviour:
- Interface: one clock (Clk); Reset is synchronous and active-high. No other clock or reset exists.
- Reset (any cycle, including mid-debounce or while Valid=1) clears the following on the next edge:
  - both synchronizer stages, candidate register and counter;
  - state -> IDLE;
  - Data_out=8'h00, Valid=0, Multi_err=0.
- Synchronizer: two flops on Keys_in. S denotes the second-stage output; the FSM sees only S.
- onehot(S) means exactly one bit of S is set; all-zero and multi-bit values are not one-hot.
- FSM states: IDLE, DEBOUNCE, PRESSED, WAIT_RELEASE.
- IDLE:
  - onehot(S): candidate<=S, cnt<=1, go to DEBOUNCE.
  - Otherwise stay in IDLE; no error pulse.
- DEBOUNCE:
  - S==candidate and cnt==DEBOUNCE_CYCLES-1: Data_out<=candidate, Valid<=1, go to PRESSED.
  - S==candidate otherwise: cnt<=cnt+1.
  - S!=candidate: cnt<=0, go to IDLE. If popcount(S)>1, Multi_err=1 for exactly one cycle.
- PRESSED:
  - Data_out and Valid are held.
  - Ack=1 on an edge: Valid<=0, cnt<=0, go to WAIT_RELEASE, regardless of S.
  - Key activity in PRESSED is ignored.
- WAIT_RELEASE:
  - S==0: cnt<=cnt+1; at cnt==DEBOUNCE_CYCLES-1, go to IDLE.
  - Any S!=0: cnt<=0 and stay.
- Data_out holds the last accepted code until the next acceptance; it is never cleared except by Reset.
- Latency: with Keys_in stable from sampling edge k, Valid rises after edge k+DEBOUNCE_CYCLES+1, i.e. N+2 edges after first sample.
- Valid falls on the edge that samples Ack=1.
- Ack while Valid=0 has no effect.
- Earliest re-acceptance after release: the release debounce takes DEBOUNCE_CYCLES samples, then the press debounce begins again from IDLE.
- Glitches shorter than DEBOUNCE_CYCLES samples never produce Valid.
- Multi_err never asserts in PRESSED, WAIT_RELEASE or IDLE.
- The counter never wraps; it is bounded by DEBOUNCE_CYCLES-1.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4.
1. Reset, then Keys_in=8'h08 held -> Valid=1 and Data_out=8'h08 after the 6th edge from first sample; Multi_err stays 0.
2. Key 8'h40 pressed and Ack held low for 20 cycles -> Valid and Data_out=8'h40 stay stable. Ack pulsed for 1 cycle -> Valid=0 next edge, Data_out stays 8'h40.
3. Keys_in=8'h02 for 2 cycles, then 8'h00 -> no Valid, state returns to IDLE, Data_out unchanged, Multi_err=0.
4. Keys_in=8'h01 for 2 cycles, then 8'h81 -> Multi_err pulses exactly 1 cycle, no Valid. Holding 8'h81 gives no further pulse and no Valid.
5. After an acked 8'h04 press:
   - key still held, then 8'h20 pressed without any release -> no Valid;
   - 8'h00 held for 4 samples, then 8'h20 -> Valid with Data_out=8'h20;
   - release of 3 samples interrupted by 8'h20 -> the release count restarts.
6. Reset asserted while in DEBOUNCE and while Valid=1 -> next edge Valid=0, Data_out=8'h00, Multi_err=0. The key must be re-sampled through the full N+2 latency after Reset deasserts.

Source files
------------

// File: rtl/onehot_key_capture_if.sv
// Consumer-facing handshake bundle of the key capture stage.
// The capture stage is the master: it presents the one-hot code, the
// Valid level and the Multi_err pulse; the consumer returns Ack.
interface onehot_key_capture_if;
  logic [7:0] Data_out;
  logic       Valid;
  logic       Ack;
  logic       Multi_err;

  modport master (
    output Data_out,
    output Valid,
    output Multi_err,
    input  Ack
  );

  modport slave (
    input  Data_out,
    input  Valid,
    input  Multi_err,
    output Ack
  );
endinterface

// File: rtl/onehot_key_capture.sv
// Key capture front end for the 8-to-3 encoder.
// Raw key lines pass through a two-flop synchronizer. A single-key press is
// accepted after DEBOUNCE_CYCLES identical samples. The captured one-hot
// code is then held on Data_out with Valid high until Ack is seen. After
// that, the keys must stay fully released for DEBOUNCE_CYCLES samples
// before another press can be considered.
module onehot_key_capture #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [7:0]                  Keys_in,
  onehot_key_capture_if.master        bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    WAIT_RELEASE
  } state_t;

  logic [7:0]       sync1_q, sync2_q;
  state_t           state_q, state_d;
  logic [7:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             multi_q, multi_d;

  logic [7:0] s;
  logic       s_multi;
  logic       s_onehot;

  // Two-flop synchronizer on the asynchronous key lines.
  always_ff @(posedge Clk) begin
    // NOTE: state in clocked blocks uses <= so every flop samples pre-edge values.
    if (Reset) begin
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
    end else begin
      sync1_q <= Keys_in;
      sync2_q <= sync1_q;
    end
  end

  // Clearing the lowest set bit leaves a non-zero value only when two or more keys are high.
  assign s        = sync2_q;
  assign s_multi  = (s & (s - 8'd1)) != 8'h00;
  assign s_onehot = (s != 8'h00) && !s_multi;

  // FSM and datapath registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cand_q  <= 8'h00;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
    end
  end

  // Next-state and next-output decode for the press/release debounce FSM.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    multi_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (s_onehot) begin
          cand_d  = s;
          cnt_d   = CNT_W'(1);
          state_d = DEBOUNCE;
        end
      end

      DEBOUNCE: begin
        if (s == cand_q) begin
          if (cnt_q == CNT_LAST) begin
            data_d  = cand_q;
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = PRESSED;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          // The candidate is abandoned. Report it only when a second key caused the abort.
          cnt_d   = '0;
          state_d = IDLE;
          multi_d = s_multi;
        end
      end

      PRESSED: begin
        // Key activity is ignored here. Only the consumer's Ack moves us on.
        if (bus.Ack) begin
          valid_d = 1'b0;
          cnt_d   = '0;
          state_d = WAIT_RELEASE;
        end
      end

      WAIT_RELEASE: begin
        if (s == 8'h00) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.Data_out  = data_q;
  assign bus.Valid     = valid_q;
  assign bus.Multi_err = multi_q;

endmodule

// File: tb/tb_onehot_key_capture.sv
// Directed bench for onehot_key_capture with DEBOUNCE_CYCLES = 4.
// Inputs change 1 ns after a rising edge. Outputs are checked at the same
// point, before the next edge. With keys stable from sampling edge k,
// Valid is first seen high after edge k+5.
module tb_onehot_key_capture;

  logic       clk;
  logic       reset;
  logic [7:0] keys;
  int         n_checks;
  int         n_pass;
  int         multi_cnt;
  int         multi_base;
  logic       stable;

  onehot_key_capture_if bus ();

  onehot_key_capture #(.DEBOUNCE_CYCLES(4)) dut (
    .Clk     (clk),
    .Reset   (reset),
    .Keys_in (keys),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts every cycle in which Multi_err is seen high.
  initial multi_cnt = 0;
  always @(posedge clk) if (bus.Multi_err === 1'b1) multi_cnt <= multi_cnt + 1;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_idle_outputs(input string tag, input logic [7:0] exp_data);
    check({tag, "_valid"}, 8'(bus.Valid), 8'd0);
    check({tag, "_data"},  bus.Data_out,  exp_data);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    keys     = 8'h00;
    bus.Ack  = 1'b0;

    // Reset state.
    tick(2);
    check_idle_outputs("reset", 8'h00);
    check("reset_multi", 8'(bus.Multi_err), 8'd0);
    reset = 1'b0;

    // An Ack while nothing is presented has no effect.
    bus.Ack = 1'b1;
    tick(2);
    bus.Ack = 1'b0;
    check_idle_outputs("ack_idle", 8'h00);

    // 1: single press with exact latency.
    multi_base = multi_cnt;
    keys = 8'h08;
    tick(5);
    check("s1_valid_early", 8'(bus.Valid), 8'd0);
    tick(1);
    check("s1_valid", 8'(bus.Valid), 8'd1);
    check("s1_data", bus.Data_out, 8'h08);
    check("s1_multi", 8'(multi_cnt - multi_base), 8'd0);
    bus.Ack = 1'b1;
    tick(1);
    bus.Ack = 1'b0;
    check("s1_ack_valid", 8'(bus.Valid), 8'd0);
    keys = 8'h00;
    tick(8);

    // 2: presented code stays stable while Ack is low.
    keys = 8'h40;
    tick(6);
    check("s2_valid", 8'(bus.Valid), 8'd1);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus.Valid !== 1'b1 || bus.Data_out !== 8'h40) stable = 1'b0;
    end
    check("s2_hold", 8'(stable), 8'd1);
    bus.Ack = 1'b1;
    tick(1);
    bus.Ack = 1'b0;
    check_idle_outputs("s2_ack", 8'h40);
    keys = 8'h00;
    tick(8);

    // 3: a short glitch never produces Valid.
    multi_base = multi_cnt;
    keys = 8'h02;
    tick(2);
    keys = 8'h00;
    tick(10);
    check_idle_outputs("s3", 8'h40);
    check("s3_multi", 8'(multi_cnt - multi_base), 8'd0);

    // 4: a second key during debounce gives one Multi_err pulse and no Valid.
    multi_base = multi_cnt;
    keys = 8'h01;
    tick(2);
    keys = 8'h81;
    tick(2);
    check("s4_multi_before", 8'(bus.Multi_err), 8'd0);
    tick(1);
    check("s4_multi_pulse", 8'(bus.Multi_err), 8'd1);
    tick(1);
    check("s4_multi_after", 8'(bus.Multi_err), 8'd0);
    tick(20);
    check("s4_multi_count", 8'(multi_cnt - multi_base), 8'd1);
    check_idle_outputs("s4", 8'h40);
    keys = 8'h00;
    tick(4);

    // 5a: after an acked press, a key change without release is ignored.
    keys = 8'h04;
    tick(6);
    check("s5_valid", 8'(bus.Valid), 8'd1);
    check("s5_data", bus.Data_out, 8'h04);
    bus.Ack = 1'b1;
    tick(1);
    bus.Ack = 1'b0;
    tick(10);
    keys = 8'h20;
    tick(10);
    check_idle_outputs("s5_no_release", 8'h04);

    // 5b: exactly four released samples, then the next press at full latency.
    keys = 8'h00;
    tick(4);
    keys = 8'h20;
    tick(5);
    check("s5_rel_early", 8'(bus.Valid), 8'd0);
    tick(1);
    check("s5_rel_valid", 8'(bus.Valid), 8'd1);
    check("s5_rel_data", bus.Data_out, 8'h20);
    bus.Ack = 1'b1;
    tick(1);
    bus.Ack = 1'b0;

    // 5c: interrupted releases of three samples each restart the count.
    keys = 8'h00;
    tick(3);
    keys = 8'h20;
    tick(2);
    keys = 8'h00;
    tick(3);
    keys = 8'h10;
    tick(10);
    check_idle_outputs("s5_restart", 8'h20);
    keys = 8'h00;
    tick(8);
    keys = 8'h10;
    tick(6);
    check("s5_after_valid", 8'(bus.Valid), 8'd1);
    check("s5_after_data", bus.Data_out, 8'h10);

    // 6a: Reset while Valid is high.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_idle_outputs("s6_rst_valid", 8'h00);
    check("s6_rst_valid_multi", 8'(bus.Multi_err), 8'd0);
    tick(5);
    check("s6_relatch_early", 8'(bus.Valid), 8'd0);
    tick(1);
    check("s6_relatch_valid", 8'(bus.Valid), 8'd1);
    check("s6_relatch_data", bus.Data_out, 8'h10);
    bus.Ack = 1'b1;
    tick(1);
    bus.Ack = 1'b0;
    keys = 8'h00;
    tick(8);

    // 6b: Reset in the middle of a debounce.
    keys = 8'h08;
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_idle_outputs("s6_rst_deb", 8'h00);
    check("s6_rst_deb_multi", 8'(bus.Multi_err), 8'd0);
    tick(5);
    check("s6_deb_early", 8'(bus.Valid), 8'd0);
    tick(1);
    check("s6_deb_valid", 8'(bus.Valid), 8'd1);
    check("s6_deb_data", bus.Data_out, 8'h08);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
